// File: rtl/core_pkg.sv
// Shared RV32 core definitions: data width, reset PC and the fetch-queue entry layout.
package core_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
    logic            filled;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue_if.sv
// Instruction-memory request/response and decode handshake bundle of the fetch queue.
// master = fetch queue side, slave = memory/decode side.
interface fetch_queue_if;
  import core_pkg::*;

  logic            imem_req_valid;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_req_ready;
  logic            imem_rsp_valid;
  logic [XLEN-1:0] imem_rsp_data;

  logic            id_valid;
  logic [XLEN-1:0] id_pc;
  logic [XLEN-1:0] id_instr;
  logic            id_ready;

  modport master (
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
    output id_valid, id_pc, id_instr,
    input  id_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data,
    input  id_valid, id_pc, id_instr,
    output id_ready
  );

endinterface

// File: rtl/fetch_queue.sv
// In-order instruction fetch queue between the PC register and IF/ID, with jump flush.
// Define FETCH_QUEUE_BYPASS_EN to forward a response that fills the head entry straight to decode.
module fetch_queue
  import core_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] cur_pc,
  input  logic            jump,
  output logic            stop,
  fetch_queue_if.master   bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef logic [PTR_W-1:0] ptr_t;
  typedef logic [CNT_W-1:0] cnt_t;

  localparam cnt_t CNT_FULL = cnt_t'(DEPTH);
  localparam cnt_t CNT_ONE  = cnt_t'(1);
  localparam ptr_t PTR_ONE  = ptr_t'(1);

  logic [XLEN-1:0]  pc_mem    [DEPTH];
  logic [XLEN-1:0]  instr_mem [DEPTH];
  logic [DEPTH-1:0] filled_q;

  ptr_t head_q, tail_q, fill_q;
  cnt_t count_q, unfilled_q, drop_q;

  fetch_entry_t head_entry;
  logic         req_fire;
  logic         rsp_keep;
  logic         rsp_drop;
  logic         bypass_hit;
  logic         pop;

  always_comb begin
    head_entry.pc     = pc_mem[head_q];
    head_entry.instr  = instr_mem[head_q];
    head_entry.filled = filled_q[head_q];
  end

  // The full check uses the registered count, so a same-cycle pop never frees a slot early.
  assign bus.imem_req_valid = !reset && !jump && (count_q < CNT_FULL) && (drop_q == '0);
  assign bus.imem_req_addr  = cur_pc;
  assign req_fire           = bus.imem_req_valid && bus.imem_req_ready;
  assign stop               = !req_fire;

  // Responses in a jump cycle belong to the flushed stream and are folded into drop instead.
  assign rsp_keep = !reset && !jump && bus.imem_rsp_valid && (drop_q == '0);
  assign rsp_drop = !reset && !jump && bus.imem_rsp_valid && (drop_q != '0);

`ifdef FETCH_QUEUE_BYPASS_EN
  // No filled entries ahead of the fill pointer means the response lands in the head entry.
  assign bypass_hit = rsp_keep && (count_q != '0) && (unfilled_q == count_q);
`else
  assign bypass_hit = 1'b0;
`endif

  assign bus.id_valid = !reset && !jump &&
                        (((count_q != '0) && head_entry.filled) || bypass_hit);
  assign bus.id_pc    = head_entry.pc;
  assign bus.id_instr = bypass_hit ? bus.imem_rsp_data : head_entry.instr;

  assign pop = bus.id_valid && bus.id_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q     <= '0;
      tail_q     <= '0;
      fill_q     <= '0;
      count_q    <= '0;
      unfilled_q <= '0;
      drop_q     <= '0;
      filled_q   <= '0;
    end else if (jump) begin
      head_q     <= tail_q;
      fill_q     <= tail_q;
      count_q    <= '0;
      unfilled_q <= '0;
      drop_q     <= drop_q + unfilled_q - cnt_t'(bus.imem_rsp_valid);
    end else begin
      if (req_fire) begin
        filled_q[tail_q] <= 1'b0;
        tail_q           <= tail_q + PTR_ONE;
      end
      if (rsp_keep) begin
        if (!(bypass_hit && pop)) begin
          filled_q[fill_q] <= 1'b1;
        end
        fill_q <= fill_q + PTR_ONE;
      end
      if (rsp_drop) begin
        drop_q <= drop_q - CNT_ONE;
      end
      if (pop) begin
        head_q <= head_q + PTR_ONE;
      end
      count_q    <= count_q + cnt_t'(req_fire) - cnt_t'(pop);
      unfilled_q <= unfilled_q + cnt_t'(req_fire) - cnt_t'(rsp_keep);
    end
  end

  // NOTE: payload arrays carry no reset; validity is owned entirely by count/filled,
  // so resetting them would only add reset fan-out to wide storage.
  always_ff @(posedge clk) begin
    if (req_fire) begin
      pc_mem[tail_q] <= cur_pc;
    end
    if (rsp_keep) begin
      instr_mem[fill_q] <= bus.imem_rsp_data;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: PC register and fixed-latency in-order memory are modelled here.
// Works with and without FETCH_QUEUE_BYPASS_EN.
module tb_fetch_queue;
  import core_pkg::*;

`ifdef FETCH_QUEUE_BYPASS_EN
  localparam logic BYP = 1'b1;
`else
  localparam logic BYP = 1'b0;
`endif

  typedef struct {
    logic [XLEN-1:0] addr;
    int              due;
  } pend_t;

  logic            clk    = 1'b0;
  logic            reset  = 1'b1;
  logic            jump   = 1'b0;
  logic [XLEN-1:0] cur_pc = '0;
  logic            stop;

  fetch_queue_if bus ();

  fetch_queue #(.DEPTH(4)) dut (
    .clk    (clk),
    .reset  (reset),
    .cur_pc (cur_pc),
    .jump   (jump),
    .stop   (stop),
    .bus    (bus.master)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  pend_t           pend [$];
  int              cyc    = 0;
  int              lat    = 1;
  logic [XLEN-1:0] pc_reg = RESET_PC;
  logic [XLEN-1:0] exp_pc;

  logic            o_stop, o_rv, o_iv, o_acc;
  logic [XLEN-1:0] o_ra, o_ipc, o_iins;

  function automatic logic [XLEN-1:0] mem_word(input logic [XLEN-1:0] a);
    return a ^ 32'h5A5A_0013;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // One clock cycle: drive at the falling edge, sample 1 ns later, advance the environment.
  task automatic step(input logic rst_i, input logic jmp_i, input logic [XLEN-1:0] tgt_i,
                      input logic idr_i, input logic rdy_i);
    logic rsp;
    @(negedge clk);
    reset              = rst_i;
    jump               = jmp_i;
    cur_pc             = pc_reg;
    bus.id_ready       = idr_i;
    bus.imem_req_ready = rdy_i;
    rsp                = !rst_i && (pend.size() > 0) && (pend[0].due == cyc);
    bus.imem_rsp_valid = rsp;
    bus.imem_rsp_data  = rsp ? mem_word(pend[0].addr) : '0;
    #1;
    o_stop = stop;
    o_rv   = bus.imem_req_valid;
    o_ra   = bus.imem_req_addr;
    o_iv   = bus.id_valid;
    o_ipc  = bus.id_pc;
    o_iins = bus.id_instr;
    o_acc  = o_rv && rdy_i;
    if (rst_i) begin
      pend.delete();
      pc_reg = RESET_PC;
    end else begin
      if (rsp) void'(pend.pop_front());
      if (o_acc) pend.push_back('{addr: o_ra, due: cyc + lat});
      if (jmp_i)      pc_reg = tgt_i;
      else if (o_acc) pc_reg = pc_reg + 32'd4;
    end
    cyc++;
  endtask

  task automatic expect_pop(input string tag);
    check({tag, "_valid"}, 32'(o_iv), 32'd1);
    check({tag, "_pc"}, o_ipc, exp_pc);
    check({tag, "_instr"}, o_iins, mem_word(exp_pc));
    exp_pc = exp_pc + 32'd4;
  endtask

  task automatic wait_first(input string tag, input logic [XLEN-1:0] pc_exp);
    bit seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      step(1'b0, 1'b0, '0, 1'b1, 1'b1);
      seen = o_iv;
    end
    check({tag, "_seen"}, 32'(seen), 32'd1);
    if (seen) begin
      check({tag, "_first_pc"}, o_ipc, pc_exp);
      check({tag, "_first_instr"}, o_iins, mem_word(pc_exp));
    end
  endtask

  initial begin
    bus.imem_req_ready = 1'b0;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = '0;
    bus.id_ready       = 1'b0;

    // Reset held 3 cycles, L=1, then streaming from RESET_PC.
    lat = 1;
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, '0, 1'b1, 1'b1);
      check("rst_stop", 32'(o_stop), 32'd1);
      check("rst_req_valid", 32'(o_rv), 32'd0);
      check("rst_id_valid", 32'(o_iv), 32'd0);
    end
    step(1'b0, 1'b0, '0, 1'b1, 1'b1);
    check("t1_req_valid", 32'(o_rv), 32'd1);
    check("t1_req_addr", o_ra, 32'h0);
    check("t1_stop", 32'(o_stop), 32'd0);
    check("t1_id_valid_n", 32'(o_iv), 32'd0);
    exp_pc = 32'h0;
    step(1'b0, 1'b0, '0, 1'b1, 1'b1);
    check("t1_latency", 32'(o_iv), 32'(BYP));
    if (o_iv) expect_pop("t1_byp");
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b0, '0, 1'b1, 1'b1);
      expect_pop("t1_stream");
    end

    // Decode stalled for 10 cycles: exactly DEPTH requests, then one pop frees one slot.
    step(1'b1, 1'b0, '0, 1'b0, 1'b1);
    begin
      int              n_acc = 0;
      logic [XLEN-1:0] last  = '0;
      for (int i = 0; i < 10; i++) begin
        step(1'b0, 1'b0, '0, 1'b0, 1'b1);
        if (o_acc) begin
          n_acc++;
          last = o_ra;
        end
      end
      check("t2_num_accepted", 32'(n_acc), 32'd4);
      check("t2_last_addr", last, 32'hC);
    end
    check("t2_full_stop", 32'(o_stop), 32'd1);
    check("t2_full_req", 32'(o_rv), 32'd0);
    step(1'b0, 1'b0, '0, 1'b1, 1'b1);
    check("t2_pop_valid", 32'(o_iv), 32'd1);
    check("t2_pop_pc", o_ipc, 32'h0);
    check("t2_pop_cycle_req", 32'(o_rv), 32'd0);
    step(1'b0, 1'b0, '0, 1'b0, 1'b1);
    check("t2_refill_req", 32'(o_rv), 32'd1);
    check("t2_refill_addr", o_ra, 32'h10);
    step(1'b0, 1'b0, '0, 1'b0, 1'b1);
    check("t2_refull_req", 32'(o_rv), 32'd0);
    check("t2_refull_stop", 32'(o_stop), 32'd1);

    // Drain from full with continuous refills; head/tail wrap several times.
    exp_pc = 32'h4;
    for (int i = 0; i < 12; i++) begin
      step(1'b0, 1'b0, '0, 1'b1, 1'b1);
      expect_pop("t5_wrap");
    end

    // L=3, two requests outstanding, jump to 0x100: both responses discarded.
    lat = 3;
    step(1'b1, 1'b0, '0, 1'b1, 1'b1);
    step(1'b0, 1'b0, '0, 1'b1, 1'b1);
    check("t3_acc0", 32'(o_acc), 32'd1);
    step(1'b0, 1'b0, '0, 1'b1, 1'b1);
    check("t3_acc1_addr", o_ra, 32'h4);
    step(1'b0, 1'b1, 32'h100, 1'b1, 1'b1);
    check("t3_jump_id_valid", 32'(o_iv), 32'd0);
    check("t3_jump_req", 32'(o_rv), 32'd0);
    step(1'b0, 1'b0, '0, 1'b1, 1'b1);
    check("t3_drop2_req", 32'(o_rv), 32'd0);
    check("t3_drop2_id_valid", 32'(o_iv), 32'd0);
    step(1'b0, 1'b0, '0, 1'b1, 1'b1);
    check("t3_drop1_req", 32'(o_rv), 32'd0);
    check("t3_drop1_id_valid", 32'(o_iv), 32'd0);
    step(1'b0, 1'b0, '0, 1'b1, 1'b1);
    check("t3_target_req", 32'(o_rv), 32'd1);
    check("t3_target_addr", o_ra, 32'h100);
    wait_first("t3", 32'h100);

    // Response coincides with jump, one outstanding: discarded, drop stays 0.
    lat = 1;
    step(1'b1, 1'b0, '0, 1'b1, 1'b1);
    step(1'b0, 1'b0, '0, 1'b1, 1'b1);
    check("t4_acc0", 32'(o_acc), 32'd1);
    step(1'b0, 1'b1, 32'h200, 1'b1, 1'b1);
    check("t4_jump_id_valid", 32'(o_iv), 32'd0);
    check("t4_jump_req", 32'(o_rv), 32'd0);
    step(1'b0, 1'b0, '0, 1'b1, 1'b1);
    check("t4_target_req", 32'(o_rv), 32'd1);
    check("t4_target_addr", o_ra, 32'h200);
    wait_first("t4", 32'h200);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule
